muldiv_unit: RTL

Iterative multiply/divide unit with HI/LO registers, parametrised in operand width, for the pipelined MIPS core. It sits beside the EX-stage ALU and accepts MULT/MULTU/DIV/DIVU from the E stage. It runs for a fixed number of cycles and exposes busy, which the hazard unit uses to stall MFHI/MFLO and any new mul/div in D. It also services MTHI/MTLO and aborts on an E-stage flush.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_step.sv | 40 ++++
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and helpers for the iterative multiply/divide unit.
//   md_op_t    : operation encoding as presented on the unit's op port
//   md_state_t : sequencer states (IDLE, RUN, FIX)
//   abs_val    : two's-complement magnitude of a zero-extended operand
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    // abs_val works on a fixed maximum width so it can serve any WIDTH up to
    // 64. Callers zero-extend their operand and truncate the result back.
    localparam int ABS_MAX_W = 64;

    function automatic logic [ABS_MAX_W-1:0] abs_val(input logic [ABS_MAX_W-1:0] x,
                                                     input logic                 neg);
        return neg ? (~x + ABS_MAX_W'(1)) : x;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration of the multiply/divide datapath.
//   is_div   : 1 = restoring shift-subtract, 0 = shift-add
//   acc      : {upper, lower} working accumulator
//              multiply: {partial product, remaining multiplier bits}
//              divide  : {partial remainder, remaining dividend / quotient bits}
//   operand  : multiplicand (multiply) or divisor (divide), both magnitudes
//   acc_next : accumulator after this iteration
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] partial;
    logic [WIDTH:0] divisor_x;
    logic           ge;

    always_comb begin
        acc_next  = acc;
        // Multiply: add multiplicand to the upper half when the current
        // multiplier bit is set; the carry shifts into the MSB.
        sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        // Divide: the shifted-in remainder needs one extra bit because the
        // previous remainder may be as large as divisor-1.
        partial   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        divisor_x = {1'b0, operand};
        ge        = (partial >= divisor_x);
        if (is_div) begin
            acc_next = {(ge ? WIDTH'(partial - divisor_x) : partial[WIDTH-1:0]),
                        acc[WIDTH-2:0], ge};
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
//   clk, reset   : rising-edge clock, asynchronous active-high reset
//   start, op    : launch an operation with operands a (rs) and b (rt)
//   flush        : abort an in-flight operation without touching HI/LO
//   mthi, mtlo   : write wdata into HI / LO (only while idle)
//   busy         : operation in progress (RUN or FIX)
//   done         : one-cycle pulse after HI/LO were written by an operation
//   div_zero     : sticky flag, last division had a zero divisor
//   hi, lo       : HI/LO registers
//   state        : current sequencer state, for observation
//
// Handshake: start is accepted only when busy is low and flush is low in the
// same cycle; there is no separate ready, busy low is the ready condition.
// Results appear WIDTH+1 edges after the accepting edge, flagged by done.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output md_state_t        state
);

    localparam int               CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    md_state_t          cur_state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   a_raw;
    logic               is_div;
    logic               neg_main;   // product or quotient sign
    logic               neg_rem;    // remainder sign

    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        signed_op = (op == MD_MULT) || (op == MD_DIV);
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        a_mag     = WIDTH'(abs_val(ABS_MAX_W'(a), a_neg));
        b_mag     = WIDTH'(abs_val(ABS_MAX_W'(b), b_neg));
        prod_fix  = neg_main ? -acc : acc;
        quo_fix   = neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div),
        .acc      (acc),
        .operand  (operand),
        .acc_next (acc_next)
    );

    assign busy  = (cur_state != IDLE);
    assign state = cur_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            operand   <= '0;
            a_raw     <= '0;
            is_div    <= 1'b0;
            neg_main  <= 1'b0;
            neg_rem   <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (cur_state)
                IDLE: begin
                    if (start && !flush) begin
                        is_div    <= op[1];
                        neg_main  <= a_neg ^ b_neg;
                        neg_rem   <= a_neg;
                        a_raw     <= a;
                        // Multiply keeps the multiplier in the lower half;
                        // divide keeps the dividend there.
                        operand   <= op[1] ? b_mag : a_mag;
                        acc       <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                        cnt       <= '0;
                        cur_state <= RUN;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                RUN: begin
                    if (flush) begin
                        cur_state <= IDLE;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST) cur_state <= FIX;
                    end
                end
                FIX: begin
                    cur_state <= IDLE;
                    if (!flush) begin
                        done <= 1'b1;
                        if (is_div) begin
                            if (operand == '0) begin
                                lo       <= '1;
                                hi       <= a_raw;
                                div_zero <= 1'b1;
                            end else begin
                                lo       <= quo_fix;
                                hi       <= rem_fix;
                                div_zero <= 1'b0;
                            end
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                    end
                end
                default: cur_state <= IDLE;
            endcase
        end
    end

endmodule
